// File: rtl/ble_cfg.sv
// Scan-configured basic logic element: K-input LUT plus user flop, configured
// through a SCAN_W-bit shift chain that cascades cell-to-cell via SOUT->SIN.
module ble_cfg #(
    parameter int K      = 5,
    parameter int SCAN_W = 1
) (
    input  logic              UCLK,
    input  logic              RST,
    input  logic [K-1:0]      A,
    input  logic              CE,
    input  logic              FRST,
    input  logic              SE,
    input  logic [SCAN_W-1:0] SIN,
    output logic [SCAN_W-1:0] SOUT,
    output logic              F,
    output logic              CFG_DONE
);

    localparam int LUT_BITS  = 1 << K;
    localparam int CFG_BITS  = LUT_BITS + 2;
    localparam int SHIFTS    = (CFG_BITS + SCAN_W - 1) / SCAN_W;
    localparam int CHAIN_LEN = SHIFTS * SCAN_W;
    localparam int CNT_W     = $clog2(SHIFTS + 1);
    localparam logic [CNT_W-1:0] SHIFTS_C = CNT_W'(SHIFTS);

    logic [CHAIN_LEN-1:0] chain_q, chain_d, chain_shift;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 ff_q, ff_d;
    logic [LUT_BITS-1:0]  lut_bits;
    logic                 lut, sel, init;

    // A chain only one word long is simply replaced by SIN on every shift.
    if (SHIFTS == 1) begin : g_single_word
        assign chain_shift = SIN;
    end else begin : g_multi_word
        assign chain_shift = {chain_q[CHAIN_LEN-SCAN_W-1:0], SIN};
    end

    assign lut_bits = chain_q[LUT_BITS-1:0];
    assign lut      = lut_bits[A];
    assign sel      = chain_q[LUT_BITS];
    assign init     = chain_q[LUT_BITS+1];

    assign SOUT     = chain_q[CHAIN_LEN-1 -: SCAN_W];
    assign F        = sel ? ff_q : lut;
    assign CFG_DONE = (cnt_q == SHIFTS_C);

    assign cnt_inc  = (cnt_q == SHIFTS_C) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        chain_d = chain_q;
        cnt_d   = cnt_q;
        ff_d    = ff_q;
        if (SE) begin
            // Shifting owns the flop: CE/FRST are ignored, and the completing
            // shift loads INIT from the chain as it will be after this edge.
            chain_d = chain_shift;
            cnt_d   = cnt_inc;
            if (cnt_inc == SHIFTS_C) begin
                ff_d = chain_shift[LUT_BITS+1];
            end
        end else if (FRST) begin
            ff_d = init;
        end else if (CE) begin
            ff_d = lut;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge UCLK) begin
        if (RST) begin
            chain_q <= '0;
            cnt_q   <= '0;
            ff_q    <= 1'b0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
        end
    end

endmodule

// File: tb/tb_ble_cfg.sv
// Scoreboard bench for ble_cfg: a narrow (K=4, SCAN_W=1) and a wide (K=4,
// SCAN_W=4) instance driven by directed vectors with hand-computed results.
module tb_ble_cfg;

    localparam int F_OUT = 0;
    localparam int D_OUT = 1;
    localparam int S_OUT = 2;

    typedef struct {
        string      tag;
        bit         wide;
        int         kind;
        logic [3:0] v;
    } exp_t;

    logic       UCLK;
    logic       RST;
    logic [3:0] A1, A4;
    logic       CE1, CE4, FRST1, FRST4, SE1, SE4;
    logic [0:0] SIN1, SOUT1;
    logic [3:0] SIN4, SOUT4;
    logic       F1, F4, D1, D4;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    ble_cfg #(.K(4), .SCAN_W(1)) dut1 (
        .UCLK(UCLK), .RST(RST), .A(A1), .CE(CE1), .FRST(FRST1), .SE(SE1),
        .SIN(SIN1), .SOUT(SOUT1), .F(F1), .CFG_DONE(D1)
    );

    ble_cfg #(.K(4), .SCAN_W(4)) dut4 (
        .UCLK(UCLK), .RST(RST), .A(A4), .CE(CE4), .FRST(FRST4), .SE(SE4),
        .SIN(SIN4), .SOUT(SOUT4), .F(F4), .CFG_DONE(D4)
    );

    initial UCLK = 1'b0;
    always #5 UCLK = ~UCLK;

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] actual(input bit wide, input int kind);
        case (kind)
            F_OUT:   return wide ? {3'b0, F4} : {3'b0, F1};
            D_OUT:   return wide ? {3'b0, D4} : {3'b0, D1};
            default: return wide ? SOUT4 : {3'b0, SOUT1};
        endcase
    endfunction

    // Monitor: outputs are compared at the falling edge, mid-cycle.
    always @(negedge UCLK) begin
        while (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.tag, actual(mon_e.wide, mon_e.kind), mon_e.v);
        end
    end

    task automatic push(input string tag, input bit wide, input int kind, input logic [3:0] v);
        exp_t e;
        e.tag  = tag;
        e.wide = wide;
        e.kind = kind;
        e.v    = v;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge UCLK);
        #1;
    endtask

    // Full 18-bit load of the narrow cell, first bit (INIT) shifted first.
    task automatic load1(input logic [17:0] cfg, input string tag);
        for (int i = 17; i >= 0; i--) begin
            SIN1 = cfg[i];
            SE1  = 1'b1;
            tick();
            if (i == 17) push({tag, "_done_s1"}, 0, D_OUT, 4'h0);
            if (i == 7)  push({tag, "_done_s11"}, 0, D_OUT, 4'h0);
            if (i == 1)  push({tag, "_done_s17"}, 0, D_OUT, 4'h0);
        end
        SE1 = 1'b0;
        push({tag, "_done_s18"}, 0, D_OUT, 4'h1);
        push({tag, "_sout"}, 0, S_OUT, {3'b0, cfg[17]});
    endtask

    task automatic shift4(input logic [3:0] w);
        SIN4 = w;
        SE4  = 1'b1;
        tick();
        SE4  = 1'b0;
    endtask

    task automatic probe_f1(input logic [3:0] a, input logic exp, input string tag);
        A1 = a;
        push(tag, 0, F_OUT, {3'b0, exp});
        tick();
    endtask

    task automatic probe_f4(input logic [3:0] a, input logic exp, input string tag);
        A4 = a;
        push(tag, 1, F_OUT, {3'b0, exp});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        A1 = '0; CE1 = 1'b0; FRST1 = 1'b0; SE1 = 1'b1; SIN1 = 1'b1;
        A4 = '0; CE4 = 1'b0; FRST4 = 1'b0; SE4 = 1'b1; SIN4 = 4'hF;

        // Reset held with SE asserted: nothing may shift in.
        tick();
        tick();
        push("rst_sout1", 0, S_OUT, 4'h0);
        push("rst_done1", 0, D_OUT, 4'h0);
        push("rst_f1",    0, F_OUT, 4'h0);
        push("rst_sout4", 1, S_OUT, 4'h0);
        push("rst_done4", 1, D_OUT, 4'h0);
        push("rst_f4",    1, F_OUT, 4'h0);
        tick();
        RST = 1'b0; SE1 = 1'b0; SIN1 = 1'b0; SE4 = 1'b0; SIN4 = 4'h0;
        tick();

        // Combinational mode: AND-16 truth table.
        load1(18'h08000, "comb");
        probe_f1(4'h0, 1'b0, "comb_f_a0");
        probe_f1(4'h7, 1'b0, "comb_f_a7");
        probe_f1(4'hE, 1'b0, "comb_f_aE");
        probe_f1(4'hF, 1'b1, "comb_f_aF");

        // Second load, INIT=1 SEL=0, LUT=A5C3: table lookup and SOUT = first bit.
        load1(18'h2A5C3, "pat");
        probe_f1(4'h0, 1'b1, "pat_f_a0");
        probe_f1(4'h6, 1'b1, "pat_f_a6");
        probe_f1(4'h9, 1'b0, "pat_f_a9");
        A1 = 4'h2; CE1 = 1'b1;             // clear ff via lut=0 before the next load
        tick();
        CE1 = 1'b0; A1 = 4'h0;

        // Registered mode: SEL=1, INIT=1, ff loads INIT on completion.
        load1(18'h38000, "reg");
        push("reg_f_init", 0, F_OUT, 4'h1);
        tick();
        CE1 = 1'b1;
        push("reg_f_pre_ce", 0, F_OUT, 4'h1);
        tick();
        push("reg_f_ce", 0, F_OUT, 4'h0);
        FRST1 = 1'b1;
        tick();
        push("reg_f_frst", 0, F_OUT, 4'h1);
        FRST1 = 1'b0;
        tick();
        push("reg_f_ce2", 0, F_OUT, 4'h0);
        CE1 = 1'b0;
        tick();
        probe_f1(4'hF, 1'b0, "reg_f_sel_hides_lut");

        // Priority: SE beats CE/FRST; only the completing shift loads INIT.
        load1(18'h1FFFF, "pri_prep");
        push("pri_prep_f", 0, F_OUT, 4'h0);
        tick();
        A1 = 4'h0; CE1 = 1'b1; FRST1 = 1'b1; SE1 = 1'b1; SIN1 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            push($sformatf("pri_f_s%0d", k), 0, F_OUT, (k == 18) ? 4'h1 : 4'h0);
        end
        push("pri_done", 0, D_OUT, 4'h1);
        SE1 = 1'b0; CE1 = 1'b0; FRST1 = 1'b0;
        tick();

        // Reset mid-load, with SE still high: partial load and count discarded.
        SE1 = 1'b1; SIN1 = 1'b1;
        repeat (7) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; SE1 = 1'b0; SIN1 = 1'b0; A1 = 4'h0;
        push("midrst_sout", 0, S_OUT, 4'h0);
        push("midrst_done", 0, D_OUT, 4'h0);
        push("midrst_f",    0, F_OUT, 4'h0);
        tick();
        load1(18'h08000, "reload");
        probe_f1(4'hF, 1'b1, "reload_f_aF");
        probe_f1(4'h0, 1'b0, "reload_f_a0");

        // Wide scan: 5 words with a 3-cycle pause after word 2.
        shift4(4'h8);
        push("w_done_s1", 1, D_OUT, 4'h0);
        shift4(4'h1);
        for (int p = 0; p < 3; p++) begin
            push($sformatf("w_done_pause%0d", p), 1, D_OUT, 4'h0);
            tick();
        end
        shift4(4'h2);
        shift4(4'h3);
        push("w_done_s4", 1, D_OUT, 4'h0);
        shift4(4'h4);
        push("w_done_s5", 1, D_OUT, 4'h1);
        push("w_sout_s5", 1, S_OUT, 4'h8);
        tick();
        probe_f4(4'h2, 1'b1, "w_f_a2");
        probe_f4(4'h3, 1'b0, "w_f_a3");
        probe_f4(4'hC, 1'b1, "w_f_aC");
        probe_f4(4'hF, 1'b0, "w_f_aF");

        // New wide load: CFG_DONE falls on first shift; words emerge after 5 shifts.
        shift4(4'h5);
        push("w2_done_s1", 1, D_OUT, 4'h0);
        push("w2_sout_s1", 1, S_OUT, 4'h1);
        shift4(4'h6);
        push("w2_sout_s2", 1, S_OUT, 4'h2);
        shift4(4'h7);
        push("w2_sout_s3", 1, S_OUT, 4'h3);
        shift4(4'h9);
        push("w2_sout_s4", 1, S_OUT, 4'h4);
        shift4(4'hA);
        push("w2_sout_s5", 1, S_OUT, 4'h5);
        push("w2_done_s5", 1, D_OUT, 4'h1);
        shift4(4'hB);
        push("w2_sout_s6", 1, S_OUT, 4'h6);
        push("w2_done_s6", 1, D_OUT, 4'h0);

        tick();
        tick();
        check("sb_drain", sb_q.size() > 15 ? 4'hF : 4'(sb_q.size()), 4'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
